// File: rtl/rate_lm_resampler_pkg.sv
// Shared constants and parameter helpers for the L/M rate converter.
package rate_pkg;

    localparam logic MODE_ZERO = 1'b0;
    localparam logic MODE_HOLD = 1'b1;

    function automatic int unsigned acc_width(input int unsigned l_up);
        return $clog2(l_up) + 1;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // M_DOWN <= L_UP guarantees a slot never needs more than one pop.
    function automatic bit params_legal(input int unsigned width, input int unsigned l_up,
                                        input int unsigned m_down, input int unsigned depth);
        return (width >= 1) && (l_up >= 1) && (l_up <= 16) && (m_down >= 1) &&
               (m_down <= l_up) && (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    localparam int unsigned DEF_L_UP       = 4;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned ACC_W          = acc_width(DEF_L_UP);
    localparam int unsigned PTR_W          = ptr_width(DEF_FIFO_DEPTH);

endpackage

// File: rtl/rate_lm_resampler_if.sv
// Sample-in / slot-out bus of the rate converter.
interface rate_lm_resampler_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             mode;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             underrun;

    modport master (
        output in_valid, in_data, mode, out_ready,
        input  in_ready, out_valid, out_data, underrun
    );

    modport slave (
        input  in_valid, in_data, mode, out_ready,
        output in_ready, out_valid, out_data, underrun
    );
endinterface

// File: rtl/rate_lm_resampler_fifo.sv
// Synchronous input FIFO; pointers carry one extra bit to tell full from empty.
module rate_fifo
    import rate_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_div3,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PtrW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW:0]    wr_ptr_q;
    logic [PtrW:0]    rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign head    = mem_q[rd_ptr_q[PtrW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk_div3) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + (PtrW + 1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (PtrW + 1)'(1);
            end
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_div3) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/rate_lm_resampler.sv
// Rational L/M resampler: zero-stuff by L_UP, keep every M_DOWN-th sample, paced by out_ready.
module rate_lm_resampler
    import rate_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned L_UP       = 4,
    parameter int unsigned M_DOWN     = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                clk_div3,
    input logic                reset,
    rate_lm_resampler_if.slave bus
);
    localparam int unsigned     AccW  = acc_width(L_UP);
    localparam logic [AccW-1:0] LUp   = AccW'(L_UP);
    localparam logic [AccW-1:0] MDown = AccW'(M_DOWN);

    if (!params_legal(WIDTH, L_UP, M_DOWN, FIFO_DEPTH)) begin : g_bad_params
        $error("rate_lm_resampler: illegal parameter combination");
    end

    logic [AccW-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic             cur_valid_q, cur_valid_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             underrun_q, underrun_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_head;
    logic             push;
    logic             pop;
    logic             load;
    logic             slot;
    logic [AccW-1:0]  acc_sum;
    logic             wrap;

    rate_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_div3  (clk_div3),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (bus.in_data),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.in_ready = !fifo_full;
    assign push         = bus.in_valid && !fifo_full;
    assign load         = !cur_valid_q && !fifo_empty;
    assign slot         = bus.out_ready && cur_valid_q;
    assign acc_sum      = acc_q + MDown;
    assign wrap         = (acc_sum >= LUp);
    // Load and slot are exclusive (cur_valid), so at most one pop per cycle.
    assign pop          = load || (slot && wrap && !fifo_empty);

    always_comb begin
        acc_d       = acc_q;
        cur_d       = cur_q;
        cur_valid_d = cur_valid_q;
        underrun_d  = underrun_q;
        out_valid_d = 1'b0;
        out_data_d  = '0;

        if (load) begin
            cur_d       = fifo_head;
            cur_valid_d = 1'b1;
        end

        if (slot) begin
            out_valid_d = 1'b1;
            if ((acc_q == '0) || (bus.mode == MODE_HOLD)) begin
                out_data_d = cur_q;
            end
            if (wrap) begin
                acc_d = acc_sum - LUp;
                if (!fifo_empty) begin
                    cur_d = fifo_head;
                end else begin
                    // Phase is kept so the next load resumes on the right grid point.
                    cur_valid_d = 1'b0;
                    underrun_d  = 1'b1;
                end
            end else begin
                acc_d = acc_sum;
            end
        end
    end

    always_ff @(posedge clk_div3) begin
        if (!reset) begin
            acc_q       <= '0;
            cur_q       <= '0;
            cur_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            underrun_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cur_q       <= cur_d;
            cur_valid_q <= cur_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            underrun_q  <= underrun_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.underrun  = underrun_q;

endmodule

// File: doc/rate_lm_resampler.md
Name: rate_lm_resampler

Overview:
Parametrised rational L/M rate converter for the sample datapath.
- Conceptually zero-stuffs the input stream by L, then keeps every M-th sample.
- Output can be zero-stuffed or sample-hold.
- Input samples are buffered in a small FIFO; output slots are paced by the downstream out_ready.
- Whole block runs in the clk_div3 domain and feeds the transmit shaping chain.

Parameters:
- WIDTH, 8, sample width in bits.
- L_UP, 4, interpolation factor; legal range 1..16.
- M_DOWN, 3, decimation factor; 1 <= M_DOWN <= L_UP is required, so a slot never needs more than one pop.
- FIFO_DEPTH, 4, input FIFO entries; power of two, at least 2.

Ports:
- clk_div3  input  1  block clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  input sample offered.
- in_data  input  WIDTH  input sample.
- in_ready  output  1  FIFO can accept; equals !full.
- mode  input  1  0 = zero-stuff, 1 = sample-hold; sampled at each output slot.
- out_ready  input  1  downstream output slot request.
- out_valid  output  1  registered; out_data is valid this cycle.
- out_data  output  WIDTH  registered resampled sample.
- underrun  output  1  sticky; a pop was required while the FIFO was empty.

Behaviour:
Clock and reset
- Clock is clk_div3; reset is synchronous, active-low.
- While reset=0: FIFO emptied, acc=0, cur=0, cur_valid=0, out_valid=0, out_data=0, underrun=0.
- in_ready=1 in the first cycle after reset release.

Input side
- Push when in_valid && in_ready.
- When full, in_ready=0 and the sample is not pushed, even if a pop occurs in the same cycle.
- Data offered with in_ready=0 is dropped; the source must hold it.

Internal state
- acc: phase accumulator, range 0..L_UP-1, width clog2(L_UP) plus 1.
- cur: current input sample register.
- cur_valid: cur holds a loaded sample.

Load
- When cur_valid=0 and the FIFO is not empty: cur <= head, pop, cur_valid <= 1.
- acc is unchanged by a load.

Slot
- A slot occurs when out_ready && cur_valid.
- In a slot cycle:
  - out_valid <= 1.
  - out_data <= cur if acc==0 or mode==1; otherwise out_data <= 0.
  - Compute s = acc + M_DOWN.
  - If s < L_UP: acc <= s.
  - If s >= L_UP: acc <= s - L_UP, and advance. If the FIFO is not empty, cur <= head and pop. If it is empty, cur_valid <= 0 and underrun <= 1.
- Non-slot cycle: out_valid <= 0, out_data <= 0.

Other rules
- Latency: a sample pushed into an empty, idle block at edge t is loaded at t+1 and appears on out_data after edge t+2, provided out_ready=1.
- Underrun recovery: the next load resumes with acc held at its wrapped value, so phase is preserved.
- underrun clears only on reset.
- A push and a pop in the same cycle are both honoured when not full; count is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH and use an extra bit to distinguish full from empty.
- L_UP == M_DOWN degenerates to passthrough: acc stays 0 and every slot pops.
- A mode change takes effect at the next slot; no reset of acc.
- Reset asserted mid-stream discards FIFO contents and cur with no partial output. out_valid is 0 in the following cycle.

Decomposition:
- Package rate_pkg holds:
  - localparam helpers ACC_W = clog2(L_UP) + 1 and PTR_W = clog2(FIFO_DEPTH).
  - MODE_ZERO = 1'b0, MODE_HOLD = 1'b1.
  - A constant function for parameter legality checks.
- One sub-module, rate_fifo: synchronous FIFO with WIDTH and DEPTH parameters, push/pop, head data, full/empty.
- Phase and slot logic lives in the top level.

Test Plan:
1. Zero-stuff, L_UP=4, M_DOWN=3, mode=0. Push 11,22,33,44,55; out_ready=1 held. Required out_data on valid cycles: 11,00,00,00,44. FIFO pops occur on slots 2, 3 and 4. underrun stays 0.
2. Same stimulus with mode=1. Required out_data: 11,11,22,33,44.
3. Underrun. Push only 11, hold out_ready=1. Required: outputs 11,00 (mode 0), then out_valid=0 and underrun=1. Then push 22. Required: output resumes after 2 cycles with phase acc=2, so 00 is emitted in mode 0.
4. Backpressure. FIFO_DEPTH=4, out_ready=0, push 6 samples. Required: in_ready drops after 4 accepts (cur not yet loaded counts separately, so 5 accepted in total). Raise out_ready: all 5 drain in order, none lost.
5. L_UP=M_DOWN=2 passthrough. Push A5,5A,FF. Required: out_data A5,5A,FF on consecutive valid cycles.
6. Reset mid-stream. Assert reset=0 during test 1 after the second output. Required: out_valid=0, in_ready=1 and underrun=0 after release. A fresh stream restarts at phase 0.
